exec_wb_stage: RTL and testbench

//  Execute + writeback stage of the 8-bit lab CPU; sits directly upstream of reg_file.
//  - Accepts decoded instructions over a valid/ready handshake.
//  - Drives reg_file read ports and takes read data back; forwards the pending writeback result.
//  - Computes an ALU result; MUL runs as an iterative multi-cycle op.
//  - Writes the result to reg_file one cycle after completion and counts retired instructions.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/seq_mul.sv | 70 +++++++
 rtl/exec_wb_stage.sv | 162 ++++++++++++++++
 tb/tb_exec_wb_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit lab CPU: default widths, opcodes and
// the exec/writeback FSM encoding.
package cpu_pkg;

  localparam int unsigned DATA_W_DFLT = 8;
  localparam int unsigned REG_AW_DFLT = 3;
  localparam int unsigned CNT_W_DFLT  = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_LI  = 3'b111;

  typedef enum logic [0:0] {
    StIdle,
    StMulBusy
  } state_e;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W busy
// cycles after start; done_o and product_o are valid in the last busy cycle.
module seq_mul #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] acc_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == CntW'(DATA_W - 1));
  assign busy_o    = busy_q;
  // Final partial product folds in combinationally so the result is ready with done_o.
  assign product_o = acc_step;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_step;
      cnt_d    = cnt_q + CntW'(1);
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute + writeback stage: operand forwarding, ALU, iterative MUL via seq_mul,
// one-cycle writeback register feeding reg_file, flags and retired counter.
module exec_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned REG_AW = REG_AW_DFLT,
  parameter int unsigned CNT_W  = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  output logic [REG_AW-1:0] read_reg_num_1,
  output logic [REG_AW-1:0] read_reg_num_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  output logic              writeReg,
  output logic [REG_AW-1:0] write_reg_num,
  output logic [DATA_W-1:0] write_data,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [CNT_W-1:0]  retired_count
);

  state_e            state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] mul_rd_q, mul_rd_d;

  logic              accept;
  logic [DATA_W-1:0] rs1_val, rs2_val, op_a, op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              mul_start, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_prod;

  assign in_ready       = (state_q == StIdle);
  assign accept         = in_valid && in_ready;
  assign read_reg_num_1 = in_rs1;
  assign read_reg_num_2 = in_rs2;

  // reg_file commits the pending result at the end of this cycle, so its read data is stale.
  assign rs1_val = (wb_valid_q && (wb_rd_q == in_rs1)) ? wb_data_q : read_data_1;
  assign rs2_val = (wb_valid_q && (wb_rd_q == in_rs2)) ? wb_data_q : read_data_2;
  assign op_a    = rs1_val;
  assign op_b    = in_use_imm ? in_imm : rs2_val;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (in_op)
      OP_ADD: {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB: begin
        alu_res   = op_a - op_b;
        alu_carry = (op_a < op_b);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLL: alu_res = op_a << op_b[2:0];
      OP_LI:  alu_res = in_imm;
      default: alu_res = '0;
    endcase
  end

  seq_mul #(
    .DATA_W(DATA_W)
  ) u_seq_mul (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (mul_start),
    .a_i      (op_a),
    .b_i      (op_b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    mul_rd_d   = mul_rd_q;
    mul_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_op == OP_MUL) begin
            state_d   = StMulBusy;
            mul_start = 1'b1;
            mul_rd_d  = in_rd;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = in_rd;
            wb_data_d  = alu_res;
            carry_d    = alu_carry;
          end
        end
      end
      StMulBusy: begin
        if (mul_busy && mul_done) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_rd_d    = mul_rd_q;
          wb_data_d  = mul_prod;
          carry_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flags and counter move together with the write pulse they describe.
    if (wb_valid_d) begin
      zero_d = (wb_data_d == '0);
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      mul_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      mul_rd_q   <= mul_rd_d;
    end
  end

  assign writeReg      = wb_valid_q;
  assign write_reg_num = wb_rd_q;
  assign write_data    = wb_data_q;
  assign flag_zero     = zero_q;
  assign flag_carry    = carry_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Scoreboard bench for exec_wb_stage: directed vectors push expected writebacks,
// a negedge monitor pops and compares every writeReg pulse.
module tb_exec_wb_stage;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SLL = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] LI  = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [2:0] in_op, in_rd, in_rs1, in_rs2;
  logic [7:0] in_imm;
  logic       in_use_imm;
  logic [2:0] read_reg_num_1, read_reg_num_2;
  logic [7:0] read_data_1, read_data_2;
  logic       writeReg;
  logic [2:0] write_reg_num;
  logic [7:0] write_data;
  logic       flag_zero, flag_carry;
  logic [15:0] retired_count;

  typedef struct {
    logic [2:0]  rd;
    logic [7:0]  data;
    logic        c;
    logic        z;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = '0;
  int          waited;

  exec_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_rd         (in_rd),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm        (in_imm),
    .in_use_imm    (in_use_imm),
    .read_reg_num_1(read_reg_num_1),
    .read_reg_num_2(read_reg_num_2),
    .read_data_1   (read_data_1),
    .read_data_2   (read_data_2),
    .writeReg      (writeReg),
    .write_reg_num (write_reg_num),
    .write_data    (write_data),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #950000;
    $display("FAIL watchdog: got no finish by cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm, input logic use_imm,
                       input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] exp_data,
                       input logic exp_c, input logic exp_z, input bit expect_wb,
                       output int n_wait);
    exp_t e;
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_use_imm = use_imm;
    read_data_1 = d1; read_data_2 = d2;
    n_wait = 0;
    @(negedge clk);
    while (!in_ready && n_wait < 20) begin
      n_wait++;
      @(negedge clk);
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    chk("read_reg_nums", {26'd0, read_reg_num_1, read_reg_num_2}, {26'd0, rs1, rs2});
    if (expect_wb) begin
      exp_cnt  = exp_cnt + 16'd1;
      e.rd     = rd;
      e.data   = exp_data;
      e.c      = exp_c;
      e.z      = exp_z;
      e.cnt    = exp_cnt;
      e.cyc    = cyc + ((op == MUL) ? 9 : 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      mon_e = sb.pop_front();
      $display("FAIL missing_wb: got no write by cycle %0d, required rd=%0d data=%02h at cycle %0d",
               cyc, mon_e.rd, mon_e.data, mon_e.cyc);
    end
    if (writeReg) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wb: got rd=%0d data=%02h at cycle %0d, required no write",
                 write_reg_num, write_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (write_reg_num !== mon_e.rd || write_data !== mon_e.data ||
            flag_carry !== mon_e.c || flag_zero !== mon_e.z ||
            retired_count !== mon_e.cnt || cyc != mon_e.cyc) begin
          failures++;
          $display({"FAIL wb_check: got rd=%0d data=%02h c=%0b z=%0b cnt=%0d cyc=%0d, ",
                    "required rd=%0d data=%02h c=%0b z=%0b cnt=%0d cyc=%0d"},
                   write_reg_num, write_data, flag_carry, flag_zero, retired_count, cyc,
                   mon_e.rd, mon_e.data, mon_e.c, mon_e.z, mon_e.cnt, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_use_imm = 1'b0; read_data_1 = '0; read_data_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_writeReg", {31'd0, writeReg}, 32'd0);
    chk("rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
    chk("rst_retired", {16'd0, retired_count}, 32'd0);
    chk("rst_wb_regs", {21'd0, write_reg_num, write_data}, 32'd0);
    @(posedge clk);
    #1;

    // Single-cycle ALU ops, carry and forwarding.
    issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'd5,   8'd3,   8'h08, 1'b0, 1'b0, 1, waited);
    issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0, 1, waited);
    issue(LI,  3'd4, 3'd1, 3'd2, 8'h0F, 1'b1, 8'h00,  8'h00,  8'h0F, 1'b0, 1'b0, 1, waited);
    issue(ADD, 3'd5, 3'd4, 3'd4, 8'h00, 1'b0, 8'h00,  8'h00,  8'h1E, 1'b0, 1'b0, 1, waited);

    // MUL: second MUL is held while the first iterates.
    issue(MUL, 3'd6, 3'd1, 3'd2, 8'h00, 1'b0, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 1, waited);
    issue(MUL, 3'd7, 3'd1, 3'd2, 8'h00, 1'b0, 8'd20, 8'd20, 8'h90, 1'b0, 1'b0, 1, waited);
    chk("mul_stall_cycles", waited, 32'd8);

    // Reset in iteration 4 of a MUL aborts it.
    issue(MUL, 3'd6, 3'd1, 3'd2, 8'h00, 1'b0, 8'd13, 8'd11, 8'h00, 1'b0, 1'b0, 0, waited);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_writeReg", {31'd0, writeReg}, 32'd0);
    chk("abort_retired", {16'd0, retired_count}, 32'd0);
    @(posedge clk);
    #1;
    idle(12);

    // Remaining opcodes, zero flag, rs2 forwarding into r0.
    issue(SUB, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 8'd3,  8'd5,  8'hFE, 1'b1, 1'b0, 1, waited);
    issue(AND, 3'd2, 3'd3, 3'd4, 8'h0F, 1'b1, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b1, 1, waited);
    issue(OR,  3'd3, 3'd4, 3'd5, 8'h05, 1'b1, 8'hA0, 8'h00, 8'hA5, 1'b0, 1'b0, 1, waited);
    issue(XOR, 3'd4, 3'd5, 3'd6, 8'h0F, 1'b1, 8'hFF, 8'h00, 8'hF0, 1'b0, 1'b0, 1, waited);
    issue(SLL, 3'd5, 3'd6, 3'd7, 8'h0B, 1'b1, 8'h81, 8'h00, 8'h08, 1'b0, 1'b0, 1, waited);
    issue(ADD, 3'd0, 3'd6, 3'd5, 8'h00, 1'b0, 8'h01, 8'h00, 8'h09, 1'b0, 1'b0, 1, waited);

    // Fill the retired counter to all-ones, then one more wraps it to zero.
    while (exp_cnt != 16'hFFFF) begin
      issue(LI, 3'd7, 3'd0, 3'd0, exp_cnt[7:0], 1'b1, 8'h00, 8'h00, exp_cnt[7:0], 1'b0,
            (exp_cnt[7:0] == 8'h00), 1, waited);
    end
    issue(LI, 3'd7, 3'd0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1, waited);
    idle(4);
    chk("wrap_retired", {16'd0, retired_count}, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
